// File: rtl/ghostbus_arb_pkg.sv
// ghostbus_arb_pkg -- shared definitions for the two-master ghostbus arbiter.
//   FSM state encoding, read-latency limits, WAIT counter type and the
//   master index constants used by ghostbus_arb and ghostbus_arb_pick.
package ghostbus_arb_pkg;

    localparam int RD_LAT_MAX = 15;
    localparam int CNT_W      = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    // FSM state encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Master indices
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // WAIT counts down to zero, so the load value is one less than the latency.
    function automatic cnt_t wait_load(input int rd_lat);
        return cnt_t'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/ghostbus_arb_pick.sv
// ghostbus_arb_pick -- combinational two-way request picker.
//   Build option: GHOSTBUS_ARB_RR_EN selects round-robin tie breaking using the
//   last-served pointer; without it master 0 always wins ties and the pointer
//   input does not exist.
// Ports:
//   i_req0, i_req1  request levels of master 0 / 1
//   i_last          last-served master (GHOSTBUS_ARB_RR_EN builds only)
//   o_grant         winning master index
//   o_valid         at least one request is pending
module ghostbus_arb_pick
    import ghostbus_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
`ifdef GHOSTBUS_ARB_RR_EN
    input  logic i_last,
`endif
    output logic o_grant,
    output logic o_valid
);

    // Grant decision: a lone requester wins outright, ties follow the build option
    always_comb begin
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
`ifdef GHOSTBUS_ARB_RR_EN
            o_grant = (i_last == M0) ? M1 : M0;
`else
            o_grant = M0;
`endif
        end else if (i_req1) begin
            o_grant = M1;
        end else begin
            o_grant = M0;
        end
    end

endmodule

// File: rtl/ghostbus_arb.sv
// ghostbus_arb -- shares one ghostbus host port between two req/ack masters,
//   one transaction in flight at a time (IDLE -> ISSUE -> [WAIT] -> DONE).
//   Build option: GHOSTBUS_ARB_RR_EN enables round-robin tie breaking (see
//   ghostbus_arb_pick); default build is fixed priority to master 0.
// Parameters: AW address width, DW data width, RD_LAT bus read latency (1..15).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req/addr/wdata/we 0 and 1     master requests (held until ack)
//   ack0/ack1, rdata0/rdata1      one-cycle completion pulse, read data
//   gb_addr/gb_din/gb_we/gb_dout  ghostbus host port
//   busy                          high whenever the FSM is not IDLE
module ghostbus_arb
    import ghostbus_arb_pkg::*;
#(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          we0,
    input  logic          we1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_din,
    input  logic [DW-1:0] gb_dout,
    output logic          gb_we,
    output logic          busy
);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_check
        $error("ghostbus_arb: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
    end

    logic [1:0]    r_state;
    logic          r_sel;
    cnt_t          r_cnt;
    logic [AW-1:0] r_gb_addr;
    logic [DW-1:0] r_gb_din;
    logic          r_gb_we;
    logic          r_ack0;
    logic          r_ack1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_busy;
    logic          w_grant;
    logic          w_valid;

`ifdef GHOSTBUS_ARB_RR_EN
    logic r_last;

    // Last-served pointer; reset to master 1 so master 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= M1;
        end else if (r_state == S_IDLE && w_valid) begin
            r_last <= w_grant;
        end else begin
            r_last <= r_last;
        end
    end
`endif

    ghostbus_arb_pick u_pick (
        .i_req0  (req0),
        .i_req1  (req1),
`ifdef GHOSTBUS_ARB_RR_EN
        .i_last  (r_last),
`endif
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    // Transaction FSM with bus, WAIT counter, ack and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sel     <= M0;
            r_cnt     <= '0;
            r_gb_addr <= '0;
            r_gb_din  <= '0;
            r_gb_we   <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_busy    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_gb_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_state   <= S_ISSUE;
                        r_sel     <= w_grant;
                        r_busy    <= 1'b1;
                        r_gb_addr <= (w_grant == M1) ? addr1  : addr0;
                        r_gb_din  <= (w_grant == M1) ? wdata1 : wdata0;
                        r_gb_we   <= (w_grant == M1) ? we1    : we0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // r_gb_we still holds the winner's direction during ISSUE
                    if (r_gb_we) begin
                        r_state <= S_DONE;
                        r_ack0  <= (r_sel == M0);
                        r_ack1  <= (r_sel == M1);
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= wait_load(RD_LAT);
                    end
                end
                S_WAIT: begin
                    if (r_cnt == cnt_t'(0)) begin
                        r_state <= S_DONE;
                        r_ack0  <= (r_sel == M0);
                        r_ack1  <= (r_sel == M1);
                        if (r_sel == M1) begin
                            r_rdata1 <= gb_dout;
                        end else begin
                            r_rdata0 <= gb_dout;
                        end
                    end else begin
                        r_cnt <= r_cnt - cnt_t'(1);
                    end
                end
                S_DONE: begin
                    // Falling back to IDLE gives the master a cycle to drop req
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign gb_addr = r_gb_addr;
    assign gb_din  = r_gb_din;
    assign gb_we   = r_gb_we;
    assign busy    = r_busy;

endmodule

// File: tb/tb_ghostbus_arb.sv
// tb_ghostbus_arb -- self-checking bench for ghostbus_arb. Three instances with
// RD_LAT = 1, 3 and 15 each sit on their own ghostbus memory model. Expected
// values come from a transaction-level model (service order, cycle arithmetic,
// reference memory).
module tb_ghostbus_arb;

    localparam int NI = 3;
    localparam int AW = 24;
    localparam int DW = 32;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 15);
    endfunction

    function automatic logic [DW-1:0] bus_default(input int a);
        return 32'h0000_0042 ^ 32'(a) ^ 32'h0000_0100;
    endfunction

    logic clk = 1'b0;
    logic mem_init;
    logic rst [NI];
    logic req0 [NI];
    logic req1 [NI];
    logic we0 [NI];
    logic we1 [NI];
    logic ack0 [NI];
    logic ack1 [NI];
    logic gb_we [NI];
    logic busy [NI];
    logic [AW-1:0] addr0 [NI];
    logic [AW-1:0] addr1 [NI];
    logic [AW-1:0] gb_addr [NI];
    logic [DW-1:0] wdata0 [NI];
    logic [DW-1:0] wdata1 [NI];
    logic [DW-1:0] rdata0 [NI];
    logic [DW-1:0] rdata1 [NI];
    logic [DW-1:0] gb_din [NI];
    logic [DW-1:0] gb_dout [NI];
    int cyc = 0;

    // reference model state
    logic          last_m [NI];
    logic [DW-1:0] ref_mem [NI][1024];
    logic [DW-1:0] exp_rd0 [NI];
    logic [DW-1:0] exp_rd1 [NI];

    int npass = 0;
    int nfail = 0;
    int nchk  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 15);
        logic [DW-1:0] mem [1024];
        logic [AW-1:0] pa [16];
        logic          fl [16];
        logic          bprev;

        ghostbus_arb #(.AW(AW), .DW(DW), .RD_LAT(L)) u_dut (
            .clk(clk), .rst(rst[g]),
            .req0(req0[g]), .req1(req1[g]),
            .addr0(addr0[g]), .addr1(addr1[g]),
            .wdata0(wdata0[g]), .wdata1(wdata1[g]),
            .we0(we0[g]), .we1(we1[g]),
            .ack0(ack0[g]), .ack1(ack1[g]),
            .rdata0(rdata0[g]), .rdata1(rdata1[g]),
            .gb_addr(gb_addr[g]), .gb_din(gb_din[g]),
            .gb_dout(gb_dout[g]), .gb_we(gb_we[g]),
            .busy(busy[g])
        );

        // ghostbus model: data valid only exactly L cycles after an address is first presented
        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 1024; i++) mem[i] <= bus_default(i);
            end else if (gb_we[g]) begin
                mem[gb_addr[g][9:0]] <= gb_din[g];
            end
            bprev <= busy[g];
            fl[0] <= busy[g] & ~bprev;
            pa[0] <= gb_addr[g];
            for (int j = 1; j < 16; j++) begin
                fl[j] <= fl[j-1];
                pa[j] <= pa[j-1];
            end
        end
        assign gb_dout[g] = (fl[L-1] === 1'b1) ? mem[pa[L-1][9:0]] : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk = nchk + 1;
        assert (obs === exp) npass = npass + 1;
        else begin
            nfail = nfail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        last_m[d]  = 1'b1;
        exp_rd0[d] = '0;
        exp_rd1[d] = '0;
    endtask

    task automatic reset_dut(input int d);
        @(posedge clk); #1;
        rst[d] = 1'b1; req0[d] = 1'b0; req1[d] = 1'b0;
        @(posedge clk); #1;
        rst[d] = 1'b0;
        model_reset(d);
    endtask

    // One request episode: active masters raise req together, each drops it after its ack.
    task automatic run_pair(input int d, input bit a0, input bit a1, input bit w0, input bit w1,
                            input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1, input string tag);
        int n, k, lt, c0, c1, at0, at1, wecnt, nwr, idx0, idx1;
        logic first;
        logic srv [2];
        bit wv [2];
        logic [AW-1:0] s_addr [2];
        logic [DW-1:0] s_data [2];
        logic [DW-1:0] e_rd [2];
        int iss [2];
        int ackc [2];
        logic [AW-1:0] o_addr [2];
        logic [DW-1:0] o_din [2];
        logic o_we [2];
        logic o_busy [2];
        logic o_gap;
        logic o_end;
        logic [DW-1:0] r0, r1;
        bit drop0, drop1;

        n = int'(a0) + int'(a1);
`ifdef GHOSTBUS_ARB_RR_EN
        first = (a0 && a1) ? ~last_m[d] : (a0 ? 1'b0 : 1'b1);
`else
        first = a0 ? 1'b0 : 1'b1;
`endif
        srv[0] = first;
        srv[1] = ~first;
        @(posedge clk); #1;
        k = cyc + 1;
        nwr = 0;
        for (int i = 0; i < n; i++) begin
            wv[i]     = srv[i] ? w1 : w0;
            s_addr[i] = srv[i] ? ad1 : ad0;
            s_data[i] = srv[i] ? d1 : d0;
            lt        = wv[i] ? 0 : lat_of(d);
            iss[i]    = (i == 0) ? k : ackc[0] + 2;
            ackc[i]   = iss[i] + 1 + lt;
            if (wv[i]) begin
                ref_mem[d][s_addr[i][9:0]] = s_data[i];
                nwr++;
                e_rd[i] = '0;
            end else begin
                e_rd[i] = ref_mem[d][s_addr[i][9:0]];
                if (srv[i]) exp_rd1[d] = e_rd[i];
                else        exp_rd0[d] = e_rd[i];
            end
            o_addr[i] = 'x; o_din[i] = 'x; o_we[i] = 1'bx; o_busy[i] = 1'bx;
        end
`ifdef GHOSTBUS_ARB_RR_EN
        last_m[d] = srv[n-1];
`endif
        idx0 = (srv[0] == 1'b0) ? 0 : 1;
        idx1 = (srv[0] == 1'b1) ? 0 : 1;

        req0[d] = a0; we0[d] = w0; addr0[d] = ad0; wdata0[d] = d0;
        req1[d] = a1; we1[d] = w1; addr1[d] = ad1; wdata1[d] = d1;
        c0 = 0; c1 = 0; at0 = -1; at1 = -1; wecnt = 0; r0 = 'x; r1 = 'x;
        drop0 = 0; drop1 = 0; o_gap = 1'bx; o_end = 1'bx;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            for (int i = 0; i < n; i++) begin
                if (cyc == iss[i]) begin
                    o_addr[i] = gb_addr[d]; o_din[i] = gb_din[d];
                    o_we[i] = gb_we[d]; o_busy[i] = busy[d];
                end
            end
            if (n == 2 && cyc == ackc[0] + 1) o_gap = busy[d];
            if (cyc == ackc[n-1] + 1) o_end = busy[d];
            if (gb_we[d]) wecnt++;
            if (ack0[d]) begin c0++; at0 = cyc; r0 = rdata0[d]; drop0 = 1; end
            if (ack1[d]) begin c1++; at1 = cyc; r1 = rdata1[d]; drop1 = 1; end
            @(posedge clk); #1;
            if (drop0) req0[d] = 1'b0;
            if (drop1) req1[d] = 1'b0;
            if (cyc > ackc[n-1] + 3) break;
        end
        req0[d] = 1'b0;
        req1[d] = 1'b0;

        for (int i = 0; i < n; i++) begin
            check({tag, "_issue_addr"}, 64'(o_addr[i]), 64'(s_addr[i]));
            check({tag, "_issue_we"}, 64'(o_we[i]), 64'(wv[i]));
            check({tag, "_issue_busy"}, 64'(o_busy[i]), 64'd1);
            if (wv[i]) check({tag, "_issue_din"}, 64'(o_din[i]), 64'(s_data[i]));
        end
        check({tag, "_ack0_count"}, 64'(c0), 64'(int'(a0)));
        check({tag, "_ack1_count"}, 64'(c1), 64'(int'(a1)));
        if (a0) begin
            check({tag, "_ack0_cycle"}, 64'(at0), 64'(ackc[idx0]));
            if (!w0) check({tag, "_rdata0"}, 64'(r0), 64'(e_rd[idx0]));
        end
        if (a1) begin
            check({tag, "_ack1_cycle"}, 64'(at1), 64'(ackc[idx1]));
            if (!w1) check({tag, "_rdata1"}, 64'(r1), 64'(e_rd[idx1]));
        end
        if (n == 2) check({tag, "_idle_gap_busy"}, 64'(o_gap), 64'd0);
        check({tag, "_end_busy"}, 64'(o_end), 64'd0);
        check({tag, "_gb_we_cycles"}, 64'(wecnt), 64'(nwr));
        check({tag, "_rdata0_hold"}, 64'(rdata0[d]), 64'(exp_rd0[d]));
        check({tag, "_rdata1_hold"}, 64'(rdata1[d]), 64'(exp_rd1[d]));
    endtask

    int   k_s, nack, acks_seen;
    int   g_cyc [4];
    logic g_win [4];
    logic g_both [4];
    logic exp_win, lastc;
    logic [DW-1:0] dat;

    initial begin
        mem_init = 1'b1;
        for (int d = 0; d < NI; d++) begin
            rst[d] = 1'b1; req0[d] = 1'b0; req1[d] = 1'b0; we0[d] = 1'b0; we1[d] = 1'b0;
            addr0[d] = '0; addr1[d] = '0; wdata0[d] = '0; wdata1[d] = '0;
            for (int i = 0; i < 1024; i++) ref_mem[d][i] = bus_default(i);
            model_reset(d);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NI; d++) rst[d] = 1'b0;
        mem_init = 1'b0;

        // reset state of every instance
        @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            check("rst_busy", 64'(busy[d]), 64'd0);
            check("rst_ack0", 64'(ack0[d]), 64'd0);
            check("rst_ack1", 64'(ack1[d]), 64'd0);
            check("rst_gb_we", 64'(gb_we[d]), 64'd0);
            check("rst_gb_addr", 64'(gb_addr[d]), 64'd0);
            check("rst_gb_din", 64'(gb_din[d]), 64'd0);
            check("rst_rdata0", 64'(rdata0[d]), 64'd0);
            check("rst_rdata1", 64'(rdata1[d]), 64'd0);
        end

        // single write from master 0, single read from master 1 (RD_LAT=3)
        run_pair(1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000010, 24'h0, 32'hDEADBEEF, 32'h0, "wr_m0");
        run_pair(1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 24'h000100, 32'h0, 32'h0, "rd_m1");
        check("rd_m1_value_42", 64'(rdata1[1]), 64'h42);

        // master 0 back-to-back episodes: one transaction each
        run_pair(1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000011, 24'h0, 32'h0000_1234, 32'h0, "b2b_a");
        run_pair(1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000011, 24'h0, 32'h0, 32'h0, "b2b_b");

        // both masters raised together and held: grant sequence
        reset_dut(1);
        @(posedge clk); #1;
        req0[1] = 1'b1; we0[1] = 1'b1; addr0[1] = 24'h000020; wdata0[1] = 32'h1111_1111;
        req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 24'h000030; wdata1[1] = 32'h2222_2222;
        k_s = cyc + 1;
        nack = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (ack0[1] || ack1[1]) begin
                g_win[nack] = ack1[1]; g_both[nack] = ack0[1] & ack1[1]; g_cyc[nack] = cyc;
                nack++;
            end
            if (nack == 4) break;
        end
        @(posedge clk); #1;
        req0[1] = 1'b0; req1[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("tie_ack_count", 64'(nack), 64'd4);
        lastc = last_m[1];
        for (int i = 0; i < nack; i++) begin
`ifdef GHOSTBUS_ARB_RR_EN
            exp_win = ~lastc;
`else
            exp_win = 1'b0;
`endif
            lastc = exp_win;
            check("tie_winner", 64'(g_win[i]), 64'(exp_win));
            check("tie_single_ack", 64'(g_both[i]), 64'd0);
            check("tie_ack_cycle", 64'(g_cyc[i]), 64'(k_s + 1 + 3 * i));
            if (exp_win) ref_mem[1][10'h030] = 32'h2222_2222;
            else         ref_mem[1][10'h020] = 32'h1111_1111;
        end
        last_m[1] = lastc;

        // reset in the first WAIT cycle of a read
        @(posedge clk); #1;
        req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 24'h000055;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(negedge clk);
        check("wait_busy_before_rst", 64'(busy[1]), 64'd1);
        @(posedge clk); #1;
        rst[1] = 1'b0; req0[1] = 1'b0;
        model_reset(1);
        @(negedge clk);
        check("mid_rst_busy", 64'(busy[1]), 64'd0);
        check("mid_rst_gb_addr", 64'(gb_addr[1]), 64'd0);
        check("mid_rst_gb_we", 64'(gb_we[1]), 64'd0);
        acks_seen = int'(ack0[1]) + int'(ack1[1]);
        repeat (6) begin
            @(negedge clk);
            acks_seen = acks_seen + int'(ack0[1]) + int'(ack1[1]);
        end
        check("mid_rst_no_ack", 64'(acks_seen), 64'd0);
        run_pair(1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000055, 24'h0, 32'h0, 32'h0, "post_rst_rd");

        // RD_LAT=1 and RD_LAT=15: read-after-write to the same address
        for (int d = 0; d < NI; d += 2) begin
            dat = $urandom;
            run_pair(d, 1'b1, 1'b0, 1'b1, 1'b0, 24'h00003A, 24'h0, dat, 32'h0, "sweep_wr");
            run_pair(d, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 24'h00003A, 32'h0, 32'h0, "sweep_rd1");
            run_pair(d, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00003A, 24'h0, 32'h0, 32'h0, "sweep_rd0");
        end

        // randomized episodes, single and simultaneous requests
        for (int it = 0; it < 24; it++) begin
            int d, pat;
            logic [AW-1:0] ra0, ra1;
            d   = int'($urandom_range(0, 2));
            pat = int'($urandom_range(1, 3));
            ra0 = 24'($urandom_range(0, 1023));
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 24'($urandom_range(0, 1023));
            run_pair(d, pat[0], pat[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ra0, ra1, $urandom, $urandom, "rand");
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
